// File: rtl/n3eif_pkg.sv
// Shared constants and types for the n3eif board-input controller.
// Register map, EVENT bit positions and the quadrature direction decoder.
package n3eif_pkg;

    localparam logic [1:0] REG_STATUS    = 2'd0;
    localparam logic [1:0] REG_EVENT     = 2'd1;
    localparam logic [1:0] REG_ROT_COUNT = 2'd2;
    localparam logic [1:0] REG_IRQ_EN    = 2'd3;

    localparam int EV_BTN_LSB  = 0;
    localparam int EV_SW_LSB   = 8;
    localparam int EV_ROT_STEP = 16;
    localparam int EV_ROT_ERR  = 17;
    localparam int EV_W        = 18;

    typedef enum logic [1:0] {
        QD_NONE,
        QD_UP,
        QD_DOWN,
        QD_ERR
    } quad_dir_e;

    // Gray AB maps to a position 0..3; the position delta gives the direction.
    function automatic quad_dir_e quad_decode(
        input logic [1:0] prev,
        input logic [1:0] cur
    );
        logic [1:0] delta;
        quad_dir_e  dir;
        delta = {cur[1], ^cur} - {prev[1], ^prev};
        case (delta)
            2'd0:    dir = QD_NONE;
            2'd1:    dir = QD_UP;
            2'd3:    dir = QD_DOWN;
            default: dir = QD_ERR;
        endcase
        return dir;
    endfunction

endpackage

// File: rtl/n3eif_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// A new level is accepted after it has differed from the old one for limit cycles.
module n3eif_debounce #(
    parameter int limit = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CW = (limit > 1) ? $clog2(limit) : 1;

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CW'(limit - 1)) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/n3eif_input_ctrl.sv
// Debounced buttons/switches, rotary decoder, sticky events and register port.
// Define N3EIF_IRQ_EN to build the IRQ_EN mask register and the irq output.
module n3eif_input_ctrl
    import n3eif_pkg::*;
#(
    parameter int C_NUM_BTN       = 4,
    parameter int C_NUM_SW        = 4,
    parameter int C_DB_CYCLES     = 66667,
    parameter int C_ROT_DB_CYCLES = 64,
    parameter int C_CNT_WIDTH     = 16
) (
    input  logic                 SPLB_Clk,
    input  logic                 SPLB_Rst,
    input  logic [C_NUM_BTN-1:0] btn,
    input  logic [C_NUM_SW-1:0]  sw,
    input  logic                 rotary_a,
    input  logic                 rotary_b,
    input  logic                 reg_rd,
    input  logic                 reg_wr,
    input  logic [1:0]           reg_addr,
    input  logic [31:0]          reg_wdata,
    output logic [31:0]          reg_rdata,
    output logic                 reg_ack,
    output logic                 irq
);

    logic [C_NUM_BTN-1:0]   btn_db, btn_prev_q;
    logic [C_NUM_SW-1:0]    sw_db, sw_prev_q;
    logic                   a_db, b_db;
    logic [1:0]             ab_db, ab_prev_q;
    logic [EV_W-1:0]        event_q, event_d, ev_set;
    logic [EV_W-1:0]        irq_en_q;
    logic [C_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]            rdata_q, rdata_d, status;
    logic                   ack_q, ack_d;
    logic                   irq_q, irq_d;
    logic                   wr_event, wr_cnt;
    logic                   unused_wdata;
    quad_dir_e              dir;

    for (genvar i = 0; i < C_NUM_BTN; i++) begin : g_btn
        n3eif_debounce #(.limit(C_DB_CYCLES)) u_db (
            .clk(SPLB_Clk), .rst(SPLB_Rst),
            .raw(btn[i]), .stable(btn_db[i])
        );
    end

    for (genvar i = 0; i < C_NUM_SW; i++) begin : g_sw
        n3eif_debounce #(.limit(C_DB_CYCLES)) u_db (
            .clk(SPLB_Clk), .rst(SPLB_Rst),
            .raw(sw[i]), .stable(sw_db[i])
        );
    end

    n3eif_debounce #(.limit(C_ROT_DB_CYCLES)) u_db_a (
        .clk(SPLB_Clk), .rst(SPLB_Rst),
        .raw(rotary_a), .stable(a_db)
    );

    n3eif_debounce #(.limit(C_ROT_DB_CYCLES)) u_db_b (
        .clk(SPLB_Clk), .rst(SPLB_Rst),
        .raw(rotary_b), .stable(b_db)
    );

    assign ab_db        = {a_db, b_db};
    assign unused_wdata = ^reg_wdata;

    always_comb begin
        dir      = quad_decode(ab_prev_q, ab_db);
        wr_event = reg_wr && (reg_addr == REG_EVENT);
        wr_cnt   = reg_wr && (reg_addr == REG_ROT_COUNT);

        ev_set = '0;
        ev_set[EV_BTN_LSB +: C_NUM_BTN] = btn_db & ~btn_prev_q;
        ev_set[EV_SW_LSB +: C_NUM_SW]   = sw_db ^ sw_prev_q;
        ev_set[EV_ROT_STEP] = (dir == QD_UP) || (dir == QD_DOWN);
        ev_set[EV_ROT_ERR]  = (dir == QD_ERR);

        // New events OR in after the clear, so a colliding set survives.
        event_d = event_q;
        if (wr_event) begin
            event_d = event_q & ~reg_wdata[EV_W-1:0];
        end
        event_d = event_d | ev_set;

        cnt_d = cnt_q;
        if (wr_cnt) begin
            cnt_d = reg_wdata[C_CNT_WIDTH-1:0];
        end else if (dir == QD_UP) begin
            cnt_d = cnt_q + C_CNT_WIDTH'(1);
        end else if (dir == QD_DOWN) begin
            cnt_d = cnt_q - C_CNT_WIDTH'(1);
        end

        status = '0;
        status[C_NUM_BTN-1:0]   = btn_db;
        status[8 +: C_NUM_SW]   = sw_db;
        status[17:16]           = ab_db;

        rdata_d = '0;
        if (reg_rd) begin
            case (reg_addr)
                REG_STATUS:    rdata_d = status;
                REG_EVENT:     rdata_d = {{(32-EV_W){1'b0}}, event_q};
                REG_ROT_COUNT: rdata_d = 32'($signed(cnt_q));
                default:       rdata_d = {{(32-EV_W){1'b0}}, irq_en_q};
            endcase
        end
        ack_d = reg_rd | reg_wr;
    end

`ifdef N3EIF_IRQ_EN
    logic [EV_W-1:0] irq_en_d;

    always_comb begin
        irq_en_d = irq_en_q;
        if (reg_wr && (reg_addr == REG_IRQ_EN)) begin
            irq_en_d = reg_wdata[EV_W-1:0];
        end
        irq_d = |(event_q & irq_en_q);
    end

    always_ff @(posedge SPLB_Clk) begin
        if (SPLB_Rst) begin
            irq_en_q <= '0;
        end else begin
            irq_en_q <= irq_en_d;
        end
    end
`else
    assign irq_en_q = '0;
    assign irq_d    = 1'b0;
`endif

    always_ff @(posedge SPLB_Clk) begin
        if (SPLB_Rst) begin
            btn_prev_q <= '0;
            sw_prev_q  <= '0;
            ab_prev_q  <= 2'b00;
            event_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            btn_prev_q <= btn_db;
            sw_prev_q  <= sw_db;
            ab_prev_q  <= ab_db;
            event_q    <= event_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
        end
    end

    assign reg_rdata = rdata_q;
    assign reg_ack   = ack_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_n3eif_input_ctrl.sv
// Directed bench for n3eif_input_ctrl with short debounce limits.
// Expected irq follows whether N3EIF_IRQ_EN is defined for the build.
module tb_n3eif_input_ctrl;

    localparam int NB = 4;
    localparam int NS = 4;
    localparam int DB = 8;
    localparam int RDB = 4;
    localparam int CW = 16;

`ifdef N3EIF_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn = '0;
    logic [NS-1:0] sw = '0;
    logic          rotary_a = 1'b0;
    logic          rotary_b = 1'b0;
    logic          reg_rd = 1'b0;
    logic          reg_wr = 1'b0;
    logic [1:0]    reg_addr = 2'd0;
    logic [31:0]   reg_wdata = '0;
    logic [31:0]   reg_rdata;
    logic          reg_ack;
    logic          irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    n3eif_input_ctrl #(
        .C_NUM_BTN(NB), .C_NUM_SW(NS),
        .C_DB_CYCLES(DB), .C_ROT_DB_CYCLES(RDB),
        .C_CNT_WIDTH(CW)
    ) dut (
        .SPLB_Clk(clk), .SPLB_Rst(rst),
        .btn(btn), .sw(sw),
        .rotary_a(rotary_a), .rotary_b(rotary_b),
        .reg_rd(reg_rd), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        reg_addr = a;
        reg_rd   = 1'b1;
        cyc(1);
        reg_rd = 1'b0;
        chk("rd_ack", {31'd0, reg_ack}, 32'd1);
        d = reg_rdata;
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] v);
        reg_addr  = a;
        reg_wdata = v;
        reg_wr    = 1'b1;
        cyc(1);
        reg_wr = 1'b0;
        chk("wr_ack", {31'd0, reg_ack}, 32'd1);
    endtask

    task automatic set_ab(input logic [1:0] v);
        rotary_a = v[1];
        rotary_b = v[0];
        cyc(10);
    endtask

    initial begin
        btn = 4'hF;
        cyc(10);
        rst = 1'b0;
        // edge 1 after release: reset values, then poll STATUS/EVENT
        cyc(1);
        chk("rst_rdata", reg_rdata, 32'd0);
        chk("rst_ack", {31'd0, reg_ack}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reg_addr = 2'd0;
        reg_rd   = 1'b1;
        cyc(1);
        chk("rst_status", reg_rdata, 32'd0);
        reg_addr = 2'd1;
        cyc(1);
        chk("rst_event", reg_rdata, 32'd0);
        reg_rd = 1'b0;
        cyc(6);
        reg_addr = 2'd0;
        reg_rd   = 1'b1;
        cyc(1);
        chk("btn_early", reg_rdata, 32'd0);
        cyc(1);
        reg_rd = 1'b0;
        chk("btn_exact", reg_rdata, 32'h0000_000F);

        btn = '0;
        cyc(30);
        reg_write(2'd1, 32'h0003_FFFF);
        reg_read(2'd1, rd);
        chk("ev_clr_all", rd, 32'd0);

        btn[0] = 1'b1;
        cyc(5);
        btn[0] = 1'b0;
        cyc(20);
        reg_read(2'd0, rd);
        chk("glitch_status", rd, 32'd0);
        reg_read(2'd1, rd);
        chk("glitch_event", rd, 32'd0);

        btn[0] = 1'b1;
        cyc(20);
        btn[0] = 1'b0;
        cyc(30);
        reg_read(2'd1, rd);
        chk("btn0_event", rd, 32'h0000_0001);
        reg_write(2'd1, 32'h0000_0001);
        reg_read(2'd1, rd);
        chk("btn0_w1c", rd, 32'd0);

        sw = 4'b0100;
        cyc(20);
        reg_read(2'd0, rd);
        chk("sw_status", rd, 32'h0000_0400);
        reg_read(2'd1, rd);
        chk("sw_event", rd, 32'h0000_0400);
        reg_write(2'd0, 32'hFFFF_FFFF);
        reg_read(2'd0, rd);
        chk("status_ro", rd, 32'h0000_0400);
        sw = '0;
        cyc(20);
        reg_write(2'd1, 32'h0003_FFFF);

        for (int i = 0; i < 3; i++) begin
            set_ab(2'b01);
            set_ab(2'b11);
            set_ab(2'b10);
            set_ab(2'b00);
        end
        reg_read(2'd2, rd);
        chk("rot_up12", rd, 32'd12);
        for (int i = 0; i < 5; i++) begin
            set_ab(2'b10);
            set_ab(2'b11);
            set_ab(2'b01);
            set_ab(2'b00);
        end
        reg_read(2'd2, rd);
        chk("rot_dn8", rd, 32'hFFFF_FFF8);
        reg_read(2'd1, rd);
        chk("rot_step_ev", rd, 32'h0001_0000);
        reg_write(2'd1, 32'h0003_FFFF);

        set_ab(2'b11);
        reg_read(2'd1, rd);
        chk("rot_err_ev", rd, 32'h0002_0000);
        reg_read(2'd2, rd);
        chk("rot_err_cnt", rd, 32'hFFFF_FFF8);
        reg_read(2'd0, rd);
        chk("ab_status", rd, 32'h0003_0000);

        reg_write(2'd2, 32'h0000_FFFF);
        reg_read(2'd2, rd);
        chk("cnt_load", rd, 32'hFFFF_FFFF);
        set_ab(2'b10);
        reg_read(2'd2, rd);
        chk("cnt_wrap", rd, 32'd0);

        reg_write(2'd1, 32'h0003_FFFF);
        reg_write(2'd3, 32'h0001_0000);
        reg_read(2'd3, rd);
        chk("irq_en_rd", rd, IRQ_ON ? 32'h0001_0000 : 32'd0);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        // step lands at edge 2+RDB+1 after the raw edge; W1C strobe hits it
        rotary_a = 1'b0;
        rotary_b = 1'b0;
        cyc(2 + RDB);
        reg_write(2'd1, 32'h0001_0000);
        cyc(3);
        reg_read(2'd1, rd);
        chk("collide_ev", rd, 32'h0001_0000);
        chk("collide_irq", {31'd0, irq}, {31'd0, IRQ_ON});
        reg_read(2'd2, rd);
        chk("collide_cnt", rd, 32'd1);
        reg_write(2'd1, 32'h0001_0000);
        cyc(2);
        chk("irq_clear", {31'd0, irq}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
